// File: rtl/riscy_mem_pkg.sv
// -----------------------------------------------------------------------------
// riscy_mem_pkg
// Shared types and constants for the RISCY data-memory responder.
//   resp_t        : one response beat {rdata, err}
//   MEM_OOR_DATA  : read data returned for out-of-range reads
//   LFSR_SEED     : reset value of the optional random-stall LFSR
//   LFSR_TAPS     : Galois feedback mask for taps 16,14,13,11
// -----------------------------------------------------------------------------
package riscy_mem_pkg;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  localparam logic [31:0] MEM_OOR_DATA = 32'hDEAD_BEEF;
  localparam logic [15:0] LFSR_SEED    = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;

endpackage

// File: rtl/riscy_mem_lat_pipe.sv
// -----------------------------------------------------------------------------
// riscy_mem_lat_pipe
// LATENCY-stage shift register of {valid, resp_t}. A beat entering in the
// accept cycle appears on the output stage LATENCY cycles later. A synchronous
// rst_i flushes every stage so no in-flight response survives reset.
// Ports:
//   clk        : clock, rising edge
//   rst_i      : synchronous active-high flush
//   in_valid   : beat enters stage 0 this cycle
//   in_resp    : beat payload
//   out_valid  : output-stage valid (drives rvalid)
//   out_resp   : output-stage payload, zero when out_valid is low
// -----------------------------------------------------------------------------
module riscy_mem_lat_pipe
  import riscy_mem_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic  clk,
  input  logic  rst_i,
  input  logic  in_valid,
  input  resp_t in_resp,
  output logic  out_valid,
  output resp_t out_resp
);

  logic  valid_q [LATENCY];
  resp_t resp_q  [LATENCY];

  // NOTE: state registers use non-blocking assignments so every stage samples
  // its predecessor's pre-edge value; blocking here would collapse the pipe.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      for (int i = 0; i < LATENCY; i++) begin
        valid_q[i] <= 1'b0;
        resp_q[i]  <= '0;
      end
    end else begin
      valid_q[0] <= in_valid;
      // Idle slots carry zero so the output reads 0 outside rvalid cycles.
      resp_q[0]  <= in_valid ? in_resp : '0;
      for (int i = 1; i < LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        resp_q[i]  <= resp_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[LATENCY-1];
  assign out_resp  = resp_q[LATENCY-1];

endmodule

// File: rtl/riscy_data_mem_responder.sv
// -----------------------------------------------------------------------------
// riscy_data_mem_responder
// Protocol-correct responder for the RISCY core data-memory port: combinational
// grant, pipelined in-order read-valid responses, and a byte-enabled word
// memory with a bench backdoor for preload and inspection.
// Optional feature macro: RISCY_MEM_RAND_STALL_EN -- adds a 16-bit Galois LFSR
// that suppresses grant on roughly 25% of cycles.
// Ports:
//   clk, rst_i            : clock and synchronous active-high reset
//   data_req_i/gnt_o      : request / grant handshake
//   data_rvalid_o         : one-cycle response pulse per accepted transaction
//   data_we_i, data_be_i  : write strobe and byte enables
//   data_addr_i           : byte address
//   data_wdata_i          : write data
//   data_rdata_o/err_o    : response data / out-of-range flag (0 when idle)
//   stall_i               : forced grant stall
//   bk_we_i/addr_i/wdata_i: backdoor word write
//   bk_rdata_o            : combinational backdoor read of mem[bk_addr_i]
// -----------------------------------------------------------------------------
module riscy_data_mem_responder
  import riscy_mem_pkg::*;
#(
  parameter int          ADDR_WIDTH      = 10,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int          LATENCY         = 1,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic                  data_req_i,
  output logic                  data_gnt_o,
  output logic                  data_rvalid_o,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [31:0]           data_addr_i,
  input  logic [31:0]           data_wdata_i,
  output logic [31:0]           data_rdata_o,
  output logic                  data_err_o,
  input  logic                  stall_i,
  input  logic                  bk_we_i,
  input  logic [ADDR_WIDTH-1:0] bk_addr_i,
  input  logic [31:0]           bk_wdata_i,
  output logic [31:0]           bk_rdata_o
);

  localparam int               DEPTH   = 2 ** ADDR_WIDTH;
  localparam int               CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [31:0]           mem [DEPTH];
  logic [31:0]           offset;
  logic                  in_range;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  stall_rand;
  logic                  room;
  logic                  accept;
  logic [CNT_W-1:0]      outstanding_q;
  resp_t                 acc_resp;
  resp_t                 out_resp;

  // ---------------------------------------------------------------------------
  // Address decode. Offset is taken relative to BASE_ADDR so the range test
  // does not overflow when the window ends at the top of the address space.
  // ---------------------------------------------------------------------------
  assign offset   = data_addr_i - BASE_ADDR;
  assign in_range = (data_addr_i >= BASE_ADDR) &&
                    ((offset >> (ADDR_WIDTH + 2)) == 32'd0);
  assign word_idx = offset[ADDR_WIDTH+1:2];

  // ---------------------------------------------------------------------------
  // Optional random stall
  // ---------------------------------------------------------------------------
`ifdef RISCY_MEM_RAND_STALL_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (rst_i) begin
      lfsr_q <= LFSR_SEED;
    end else if (lfsr_q[0]) begin
      lfsr_q <= (lfsr_q >> 1) ^ LFSR_TAPS;
    end else begin
      lfsr_q <= lfsr_q >> 1;
    end
  end

  assign stall_rand = (lfsr_q[1:0] == 2'b00);
`else
  assign stall_rand = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Grant. A retiring response frees its slot in the same cycle, so grant may
  // reassert while the counter still reads MAX_OUTSTANDING.
  // ---------------------------------------------------------------------------
  assign room       = (outstanding_q < MAX_CNT) || data_rvalid_o;
  assign data_gnt_o = data_req_i & ~stall_i & ~rst_i & room & ~stall_rand;
  assign accept     = data_req_i & data_gnt_o;

  always_ff @(posedge clk) begin
    if (rst_i) begin
      outstanding_q <= '0;
    end else begin
      unique case ({accept, data_rvalid_o})
        2'b10:   outstanding_q <= outstanding_q + ONE;
        2'b01:   outstanding_q <= outstanding_q - ONE;
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Memory array. Backdoor write first, bus lanes second: the later
  // non-blocking assignment wins on bus-enabled lanes, backdoor holds the rest.
  // ---------------------------------------------------------------------------
  // NOTE: the array has no reset branch; its contents must survive rst_i, and
  // resetting a RAM would also prevent it from mapping onto memory macros.
  always_ff @(posedge clk) begin
    if (bk_we_i) begin
      mem[bk_addr_i] <= bk_wdata_i;
    end
    if (accept && data_we_i && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (data_be_i[i]) begin
          mem[word_idx][8*i +: 8] <= data_wdata_i[8*i +: 8];
        end
      end
    end
  end

  assign bk_rdata_o = mem[bk_addr_i];

  // ---------------------------------------------------------------------------
  // Response formed in the accept cycle from the pre-edge memory contents.
  // ---------------------------------------------------------------------------
  // NOTE: every field gets a default before the branches so this block can
  // never infer a latch on a path that leaves a field unassigned.
  always_comb begin
    acc_resp = '0;
    if (!in_range) begin
      acc_resp.err   = 1'b1;
      acc_resp.rdata = data_we_i ? 32'd0 : MEM_OOR_DATA;
    end else if (!data_we_i) begin
      acc_resp.rdata = mem[word_idx];
    end
  end

  riscy_mem_lat_pipe #(
    .LATENCY (LATENCY)
  ) u_lat_pipe (
    .clk       (clk),
    .rst_i     (rst_i),
    .in_valid  (accept),
    .in_resp   (acc_resp),
    .out_valid (data_rvalid_o),
    .out_resp  (out_resp)
  );

  assign data_rdata_o = out_resp.rdata;
  assign data_err_o   = out_resp.err;

endmodule
